// File: rtl/window_stream_3x3_pkg.sv
// Shared constants for the 3x3 window streamer: tap ordering, scan states and
// the default coordinate width helper.
package window_pkg;

   localparam int TAP_UL = 0;
   localparam int TAP_UC = 1;
   localparam int TAP_UR = 2;
   localparam int TAP_ML = 3;
   localparam int TAP_MC = 4;
   localparam int TAP_MR = 5;
   localparam int TAP_DL = 6;
   localparam int TAP_DC = 7;
   localparam int TAP_DR = 8;
   localparam int NUM_TAPS = 9;

   // [row][col] of the neighbourhood -> tap slot in out_window
   localparam int TAP_MAP [3][3] = '{'{TAP_UL, TAP_UC, TAP_UR},
                                     '{TAP_ML, TAP_MC, TAP_MR},
                                     '{TAP_DL, TAP_DC, TAP_DR}};

   typedef enum logic [1:0] {
      ROW    = 2'd0,
      PADCOL = 2'd1,
      PADROW = 2'd2
   } ws_state_e;

   function automatic int idx_w_default(input int img_w, input int img_h);
      int m;
      m = (img_w > img_h) ? img_w : img_h;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/window_stream_3x3_line_buffer_ram.sv
// Single-port line buffer: asynchronous read of the addressed entry, write on
// the clock edge when enabled, so a read-then-overwrite happens in one step.
module line_buffer_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 769,
   parameter int ADDR_W = 10
) (
   input  logic              CAMERA_CLK,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge CAMERA_CLK) begin
      if (en) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/window_stream_3x3.sv
// Streaming 3x3 neighbourhood generator built on two line buffers.
// Border mode: zero fill by default, edge replication with WINDOW_BORDER_REPLICATE_EN.
module window_stream_3x3
   import window_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 768,
   parameter int IMG_H  = 512,
   parameter int IDX_W  = idx_w_default(IMG_W, IMG_H)
) (
   input  logic                       CAMERA_CLK,
   input  logic                       HRESETn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_pixel,
   input  logic                       in_sof,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_TAPS*DATA_W-1:0] out_window,
   output logic [IDX_W-1:0]           out_x,
   output logic [IDX_W-1:0]           out_y,
   output logic                       out_eof,
   output logic                       frame_err
);

   localparam int LB_AW = $clog2(IMG_W + 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = '0;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(IMG_W - 1);
   localparam logic [IDX_W-1:0] PAD_COL  = IDX_W'(IMG_W);
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(IMG_H - 1);
   localparam logic [IDX_W-1:0] PAD_ROW  = IDX_W'(IMG_H);

   // Scan position over the virtual (IMG_H+1) x (IMG_W+1) stream.
   typedef struct packed {
      ws_state_e        state;
      logic [IDX_W-1:0] row;
      logic [IDX_W-1:0] col;
   } scan_pos_t;

   localparam scan_pos_t POS_RESET = '{state: ROW, row: '0, col: '0};

   scan_pos_t pos_q, pos_d;

   logic                      stall, accept, step, sof_resync, producing;
   logic [IDX_W-1:0]          eff_row, eff_col;
   logic [DATA_W-1:0]         sample, lb0_rd, lb1_rd;
   logic [2:0][DATA_W-1:0]    col_new, col_c1_q, col_c2_q;
   logic [2:0][2:0][DATA_W-1:0] taps_raw;
   logic                      top_oob, bot_oob, left_oob, right_oob;
   logic [NUM_TAPS*DATA_W-1:0] win_d;

   assign stall      = out_valid & ~out_ready;
   assign in_ready   = (pos_q.state == ROW) & ~stall;
   assign accept     = in_valid & in_ready;
   assign step       = (pos_q.state == ROW) ? accept : ~stall;
   assign sof_resync = accept & in_sof & ((pos_q.row != IDX_ZERO) | (pos_q.col != IDX_ZERO));

   // A misplaced start-of-frame pixel is processed as if it sat at (0,0).
   assign eff_row   = sof_resync ? IDX_ZERO : pos_q.row;
   assign eff_col   = sof_resync ? IDX_ZERO : pos_q.col;
   assign sample    = (pos_q.state == ROW) ? in_pixel : '0;
   assign producing = step & (eff_row != IDX_ZERO) & (eff_col != IDX_ZERO);

   line_buffer_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W + 1),
      .ADDR_W (LB_AW)
   ) u_lb0 (
      .CAMERA_CLK (CAMERA_CLK),
      .en         (step),
      .addr       (eff_col[LB_AW-1:0]),
      .wdata      (sample),
      .rdata      (lb0_rd)
   );

   line_buffer_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W + 1),
      .ADDR_W (LB_AW)
   ) u_lb1 (
      .CAMERA_CLK (CAMERA_CLK),
      .en         (step),
      .addr       (eff_col[LB_AW-1:0]),
      .wdata      (lb0_rd),
      .rdata      (lb1_rd)
   );

   // Column vectors are indexed [0]=row r-2, [1]=row r-1, [2]=row r.
   assign col_new  = {sample, lb0_rd, lb1_rd};
   assign taps_raw = {col_new, col_c1_q, col_c2_q};

   always_ff @(posedge CAMERA_CLK) begin
      if (step) begin
         col_c1_q <= col_new;
         col_c2_q <= col_c1_q;
      end
   end

   always_comb begin
      pos_d = pos_q;
      if (step) begin
         unique case (pos_q.state)
            ROW: begin
               pos_d.row = eff_row;
               if (eff_col == LAST_COL) begin
                  pos_d.state = PADCOL;
                  pos_d.col   = PAD_COL;
               end else begin
                  pos_d.col = eff_col + IDX_ONE;
               end
            end
            PADCOL: begin
               pos_d.col = IDX_ZERO;
               if (pos_q.row == LAST_ROW) begin
                  pos_d.state = PADROW;
                  pos_d.row   = PAD_ROW;
               end else begin
                  pos_d.state = ROW;
                  pos_d.row   = pos_q.row + IDX_ONE;
               end
            end
            PADROW: begin
               if (pos_q.col == PAD_COL) begin
                  pos_d = POS_RESET;
               end else begin
                  pos_d.col = pos_q.col + IDX_ONE;
               end
            end
            default: pos_d = POS_RESET;
         endcase
      end
   end

   // Border decisions come only from the centre coordinates, never buffer data.
   assign top_oob   = (eff_row == IDX_ONE);
   assign bot_oob   = (eff_row == PAD_ROW);
   assign left_oob  = (eff_col == IDX_ONE);
   assign right_oob = (eff_col == PAD_COL);

   always_comb begin
      win_d = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
`ifdef WINDOW_BORDER_REPLICATE_EN
            int si;
            int sj;
            si = i;
            sj = j;
            if ((i == 0 && top_oob) || (i == 2 && bot_oob)) si = 1;
            if ((j == 0 && left_oob) || (j == 2 && right_oob)) sj = 1;
            win_d[TAP_MAP[i][j]*DATA_W +: DATA_W] = taps_raw[sj][si];
`else
            if ((i == 0 && top_oob) || (i == 2 && bot_oob) ||
                (j == 0 && left_oob) || (j == 2 && right_oob)) begin
               win_d[TAP_MAP[i][j]*DATA_W +: DATA_W] = '0;
            end else begin
               win_d[TAP_MAP[i][j]*DATA_W +: DATA_W] = taps_raw[j][i];
            end
`endif
         end
      end
   end

   always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pos_q      <= POS_RESET;
         out_valid  <= 1'b0;
         out_window <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_eof    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         pos_q <= pos_d;
         if (sof_resync) begin
            frame_err <= 1'b1;
         end
         if (!stall) begin
            out_valid <= producing;
            if (producing) begin
               out_window <= win_d;
               out_x      <= eff_col - IDX_ONE;
               out_y      <= eff_row - IDX_ONE;
               out_eof    <= (eff_row == PAD_ROW) && (eff_col == PAD_COL);
            end
         end
      end
   end

endmodule
